// File: rtl/pnr_pkg.sv
// pnr_pkg: register offsets and FSM state encodings shared by the acquisition controller.
package pnr_pkg;
    localparam logic [19:0] REG_CTRL    = 20'h00000;
    localparam logic [19:0] REG_STATUS  = 20'h00004;
    localparam logic [19:0] REG_WINDOW  = 20'h00008;
    localparam logic [19:0] REG_HOLDOFF = 20'h0000C;
    localparam logic [19:0] REG_THRESH  = 20'h00010;
    localparam logic [19:0] REG_COUNT   = 20'h00014;
    localparam logic [19:0] REG_LED     = 20'h00018;
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_HOLDOFF = 3'd2,
        ST_WINDOW  = 3'd3,
        ST_DONE    = 3'd4
    } state_t;
endpackage

// File: rtl/pnr_acq_regs.sv
// pnr_acq_regs: bus decode and register file; acks every strobe one cycle later.
module pnr_acq_regs
    import pnr_pkg::*;
#(
    parameter int ADC_W = 14,
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [31:0]      i_addr,
    input  logic [31:0]      i_wdata,
    input  logic             i_wen,
    input  logic             i_ren,
    input  logic             i_lock,
    input  logic [3:0]       i_status,
    input  logic [CNT_W-1:0] i_count,
    output logic             o_arm,
    output logic             o_abort,
    output logic             o_swtrig,
    output logic [15:0]      o_window,
    output logic [15:0]      o_holdoff,
    output logic [ADC_W-1:0] o_thresh,
    output logic [7:0]       o_led,
    output logic [31:0]      o_rdata,
    output logic             o_ack,
    output logic             o_err
);
    logic [19:0] w_sel;
    logic        w_ctrl_wr;
    logic        w_cfg_wr;
    logic [31:0] w_rd;
    logic        w_unused;
    logic [15:0] r_window;
    logic [15:0] r_holdoff;
    logic [ADC_W-1:0] r_thresh;
    logic [7:0]  r_led;
    logic [31:0] r_rdata;
    logic        r_ack;

    assign w_sel     = i_addr[19:0];
    assign w_unused  = ^{i_addr[31:20], i_wdata[31:16]};
    assign w_ctrl_wr = i_wen && w_sel == REG_CTRL;
    // Acquisition parameters are frozen while a capture is in flight.
    assign w_cfg_wr  = i_wen && !i_lock;
    assign o_arm     = w_ctrl_wr & i_wdata[0];
    assign o_abort   = w_ctrl_wr & i_wdata[1];
    assign o_swtrig  = w_ctrl_wr & i_wdata[2];

    assign w_rd = (w_sel == REG_STATUS)  ? {28'd0, i_status} :
                  (w_sel == REG_WINDOW)  ? {16'd0, r_window} :
                  (w_sel == REG_HOLDOFF) ? {16'd0, r_holdoff} :
                  (w_sel == REG_THRESH)  ? 32'(r_thresh) :
                  (w_sel == REG_COUNT)   ? 32'(i_count) :
                  (w_sel == REG_LED)     ? {24'd0, r_led} : 32'd0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_window  <= 16'h0100;
            r_holdoff <= '0;
            r_thresh  <= '0;
            r_led     <= '0;
            r_rdata   <= '0;
            r_ack     <= 1'b0;
        end else begin
            if (w_cfg_wr && w_sel == REG_WINDOW)  r_window  <= i_wdata[15:0];
            if (w_cfg_wr && w_sel == REG_HOLDOFF) r_holdoff <= i_wdata[15:0];
            if (w_cfg_wr && w_sel == REG_THRESH)  r_thresh  <= i_wdata[ADC_W-1:0];
            if (i_wen && w_sel == REG_LED)        r_led     <= i_wdata[7:0];
            r_rdata <= i_ren ? w_rd : 32'd0;
            r_ack   <= i_wen | i_ren;
        end
    end

    assign o_window  = r_window;
    assign o_holdoff = r_holdoff;
    assign o_thresh  = r_thresh;
    assign o_led     = r_led;
    assign o_rdata   = r_rdata;
    assign o_ack     = r_ack;
    assign o_err     = 1'b0;
endmodule

// File: rtl/pnr_acq_ctrl.sv
// pnr_acq_ctrl: triggered acquisition FSM with holdoff/window timing and
// threshold-crossing event counter.
module pnr_acq_ctrl
    import pnr_pkg::*;
#(
    parameter int ADC_W = 14,
    parameter int CNT_W = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic signed [ADC_W-1:0] adc_dat_i,
    input  logic                    ext_trig_i,
    output logic                    win_o,
    output logic                    done_o,
    output logic [7:0]              led_o,
    input  logic [31:0]             sys_addr,
    input  logic [31:0]             sys_wdata,
    input  logic                    sys_wen,
    input  logic                    sys_ren,
    output logic [31:0]             sys_rdata,
    output logic                    sys_err,
    output logic                    sys_ack
);
    state_t r_state, w_nxt, w_after_hold;
    logic w_arm, w_abort, w_swtrig, w_lock, w_trig, w_hit;
    logic [15:0] w_window, w_holdoff;
    logic signed [ADC_W-1:0] w_thresh, w_prev, r_prev;
    logic r_trig_d, r_trig_edge, r_win_first;
    logic [15:0] r_tmr;
    logic [CNT_W-1:0] r_count;

    pnr_acq_regs #(.ADC_W(ADC_W), .CNT_W(CNT_W)) u_regs (
        .clk_i(clk_i), .rst_i(rst_i),
        .i_addr(sys_addr), .i_wdata(sys_wdata), .i_wen(sys_wen), .i_ren(sys_ren),
        .i_lock(w_lock), .i_status({r_state == ST_DONE, r_state}), .i_count(r_count),
        .o_arm(w_arm), .o_abort(w_abort), .o_swtrig(w_swtrig),
        .o_window(w_window), .o_holdoff(w_holdoff), .o_thresh(w_thresh), .o_led(led_o),
        .o_rdata(sys_rdata), .o_ack(sys_ack), .o_err(sys_err)
    );

    assign w_lock       = r_state == ST_ARMED || r_state == ST_HOLDOFF || r_state == ST_WINDOW;
    assign w_trig       = r_trig_edge | w_swtrig;
    assign w_after_hold = (w_window != 16'd0) ? ST_WINDOW : ST_DONE;
    // First window sample seeds the comparison so a level already above threshold is not an event.
    assign w_prev       = r_win_first ? adc_dat_i : r_prev;
    assign w_hit        = r_state == ST_WINDOW && adc_dat_i > w_thresh && w_prev <= w_thresh;

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: if (w_arm) w_nxt = ST_ARMED;
            ST_ARMED:         if (w_trig) w_nxt = (w_holdoff != 16'd0) ? ST_HOLDOFF : w_after_hold;
            ST_HOLDOFF:       if (r_tmr == 16'd0) w_nxt = w_after_hold;
            ST_WINDOW:        if (r_tmr == 16'd0) w_nxt = ST_DONE;
            default:          w_nxt = ST_IDLE;
        endcase
        if (w_abort) w_nxt = ST_IDLE;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= ST_IDLE;
        else       r_state <= w_nxt;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_trig_d    <= 1'b0;
            r_trig_edge <= 1'b0;
            r_tmr       <= '0;
            r_prev      <= '0;
            r_win_first <= 1'b0;
            r_count     <= '0;
        end else begin
            r_trig_d    <= ext_trig_i;
            r_trig_edge <= ext_trig_i & ~r_trig_d;
            r_tmr       <= (w_nxt != r_state) ? ((w_nxt == ST_HOLDOFF) ? w_holdoff : w_window) - 16'd1
                                              : r_tmr - 16'd1;
            r_prev      <= adc_dat_i;
            r_win_first <= w_nxt == ST_WINDOW && r_state != ST_WINDOW;
            if (w_nxt == ST_ARMED && r_state != ST_ARMED) r_count <= '0;
            else if (w_hit && !(&r_count))                r_count <= r_count + CNT_W'(1);
        end
    end

    assign win_o  = r_state == ST_WINDOW;
    assign done_o = r_state == ST_DONE;
endmodule

// File: doc/pnr_acq_ctrl.md
PNR_ACQ_CTRL -- requirements
Module: pnr_acq_ctrl

Interface
REQ-001 Parameter ADC_W, default 14: ADC sample and threshold width.
REQ-002 Parameter CNT_W, default 32: event counter width.
REQ-003 Clock and reset SHALL be one clock, with asynchronous active-high reset: clk_i (in, 1, processing clock); rst_i (in, 1, active-high asynchronous reset).
REQ-004 adc_dat_i  in  ADC_W  signed ADC sample, valid every cycle.
REQ-005 ext_trig_i  in  1  external trigger, asynchronous to nothing (same clock domain), level.
REQ-006 win_o  out  1  capture window active.
REQ-007 done_o  out  1  acquisition complete, level until re-arm or abort.
REQ-008 led_o  out  8  LED register contents.
REQ-009 sys_addr  in  32  bus address; only sys_addr[19:0] decoded.
REQ-010 sys_wdata  in  32  bus write data.
REQ-011 sys_wen  in  1  bus write strobe, one cycle.
REQ-012 sys_ren  in  1  bus read strobe, one cycle.
REQ-013 sys_rdata  out  32  bus read data.
REQ-014 sys_err  out  1  bus error, always 0.
REQ-015 sys_ack  out  1  bus acknowledge.

Function
REQ-016 Register map (offset): 0x00 CTRL W (bit0 ARM, bit1 ABORT, bit2 SWTRIG, write-1 pulses, read 0); 0x04 STATUS R ({done, state[2:0]} in bits [3:0]); 0x08 WINDOW RW [15:0]; 0x0C HOLDOFF RW [15:0]; 0x10 THRESH RW [ADC_W-1:0] signed; 0x14 COUNT R [CNT_W-1:0]; 0x18 LED RW [7:0].
REQ-017 sys_ack SHALL assert exactly one cycle after any sys_wen or sys_ren, for any address; sys_rdata valid in the same cycle; unmapped addresses read 0, writes ignored.
REQ-018 States: IDLE(0), ARMED(1), HOLDOFF(2), WINDOW(3), DONE(4).
REQ-019 IDLE or DONE + ARM write -> ARMED, COUNT cleared to 0, done_o cleared, next cycle.
REQ-020 ARMED + trigger (rising edge of ext_trig_i registered once, or SWTRIG) -> HOLDOFF if HOLDOFF>0, else WINDOW if WINDOW>0, else DONE.
REQ-021 HOLDOFF SHALL last exactly HOLDOFF cycles, then -> WINDOW (or DONE if WINDOW=0).
REQ-022 WINDOW SHALL last exactly WINDOW cycles with win_o=1; then -> DONE, done_o=1.
REQ-023 In WINDOW, each cycle where adc_dat_i > THRESH and the previous sample <= THRESH (signed) SHALL increment COUNT; COUNT saturates at all-ones.
REQ-024 Previous-sample register SHALL be re-seeded with the current sample on WINDOW entry, so a sample already above threshold at entry is not counted.
REQ-025 ABORT write from any state -> IDLE next cycle, win_o=0, done_o=0, COUNT retained; ABORT wins over ARM in the same write.
REQ-026 ARM, SWTRIG in ARMED/HOLDOFF/WINDOW: ARM ignored; SWTRIG ignored outside ARMED.
REQ-027 WINDOW, HOLDOFF, THRESH writes while in ARMED/HOLDOFF/WINDOW SHALL be ignored (ack still given).
REQ-028 Triggers in IDLE, HOLDOFF, WINDOW, DONE SHALL be ignored, not queued.

Reset
REQ-029 On rst_i: state IDLE; win_o 0; done_o 0; COUNT 0; WINDOW 0x0100; HOLDOFF 0; THRESH 0; LED 0; sys_ack 0; sys_err 0; sys_rdata 0; trigger edge register 0.
REQ-030 Reset mid-acquisition SHALL abort immediately with all outputs at reset values.

Structure
REQ-031 Register offsets and state encodings SHALL live in shared package pnr_pkg.
REQ-032 Bus decode and register file in one sub-module pnr_acq_regs; FSM, counters and comparator in pnr_acq_ctrl.

Verification
REQ-033 Write WINDOW=10, HOLDOFF=3, ARM, pulse ext_trig_i -> win_o high exactly 10 cycles starting 4 cycles after registered edge; done_o=1 after.
REQ-034 THRESH=100, ramp adc 0,200,0,200,0 inside window -> COUNT=2; read 0x14 returns 2 with sys_ack one cycle after sys_ren.
REQ-035 ARM, then write ARM|ABORT (0x3) -> state IDLE, STATUS reads 0x0.
REQ-036 WINDOW=0, HOLDOFF=0, ARM, SWTRIG -> DONE next cycle, win_o never asserted.
REQ-037 Force COUNT to all-ones via long crossing stream (CNT_W=4 build) -> COUNT holds 0xF.
REQ-038 Assert rst_i during WINDOW -> win_o=0, COUNT=0, WINDOW reads 0x0100 immediately.
